// File: rtl/prog_rom_loader.sv
// prog_rom_loader: instruction ROM with synchronous fetch port and a byte-stream program loader that holds the CPU.
module prog_rom_loader #(
  parameter int ADDR_W = 14
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rom_adr_i,
  output logic [31:0]       Jpadr,
  output logic              cpu_hold,
  input  logic              dl_mode,
  input  logic              dl_byte_valid,
  input  logic [7:0]        dl_byte,
  output logic              dl_ready,
  output logic              dl_done,
  output logic [ADDR_W:0]   dl_words,
  output logic              dl_overflow
);
  typedef enum logic [1:0] {RUN, COLLECT, WRITE, DONE} state_t;
  state_t state, state_n;
  logic [31:0] mem [2**ADDR_W];
  logic [31:0] rdata, word;
  logic [ADDR_W-1:0] waddr;
  logic [1:0] byte_cnt;
  logic take;
  assign take = dl_byte_valid && dl_ready;
  assign cpu_hold = state != RUN;
  assign dl_ready = state == COLLECT;
  assign dl_done = state == DONE;
  assign Jpadr = cpu_hold ? 32'h0 : rdata;
  always_comb begin
    state_n = state;
    case (state)
      RUN:     state_n = dl_mode ? COLLECT : RUN;
      COLLECT: state_n = take ? (byte_cnt == 2'd3 ? WRITE : COLLECT)
                              : (!dl_mode ? (byte_cnt != 2'd0 ? WRITE : DONE) : COLLECT);
      WRITE:   state_n = dl_mode ? COLLECT : DONE;
      DONE:    state_n = RUN;
      default: state_n = RUN;
    endcase
  end
  // memory kept reset-free so it maps onto block RAM
  always_ff @(posedge clock) begin
    if (state == WRITE && !dl_overflow) mem[waddr] <= word;
  end
  always_ff @(posedge clock) begin
    if (reset) rdata <= '0;
    else rdata <= mem[rom_adr_i];
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RUN;
      word <= '0;
      byte_cnt <= '0;
      waddr <= '0;
      dl_words <= '0;
      dl_overflow <= 1'b0;
    end else begin
      state <= state_n;
      if (state == RUN && dl_mode) begin
        word <= '0;
        byte_cnt <= '0;
        waddr <= '0;
        dl_words <= '0;
        dl_overflow <= 1'b0;
      end
      // byte n lands at bits [31-8n -: 8], so a short word stays left-justified
      if (take) begin
        word[{~byte_cnt, 3'b111} -: 8] <= dl_byte;
        byte_cnt <= byte_cnt + 2'd1;
      end
      if (state == WRITE) begin
        if (!dl_overflow) begin
          dl_words <= dl_words + (ADDR_W+1)'(1);
          if (waddr == '1) dl_overflow <= 1'b1;
          else waddr <= waddr + ADDR_W'(1);
        end
        word <= '0;
        byte_cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_prog_rom_loader.sv
// tb_prog_rom_loader: random download sessions and fetches scored against a byte-list memory model.
module tb_prog_rom_loader;
  localparam int AW = 3;
  localparam int DEPTH = 2**AW;
  logic clock = 0, reset = 1;
  logic [AW-1:0] rom_adr_i = '0;
  logic [31:0] Jpadr;
  logic cpu_hold, dl_ready, dl_done, dl_overflow;
  logic dl_mode = 0, dl_byte_valid = 0;
  logic [7:0] dl_byte = '0;
  logic [AW:0] dl_words;
  int checks = 0, passed = 0;
  logic [31:0] fetch_q[$];
  logic [AW:0] words_q[$];
  logic ovf_q[$];
  logic [31:0] model [DEPTH];
  bit known [DEPTH];
  logic [7:0] sess[$];
  logic fetch_en = 0, fv = 0;
  bit mon_on = 0;

  always #5 clock = ~clock;

  prog_rom_loader #(.ADDR_W(AW)) dut (
    .clock(clock), .reset(reset), .rom_adr_i(rom_adr_i), .Jpadr(Jpadr),
    .cpu_hold(cpu_hold), .dl_mode(dl_mode), .dl_byte_valid(dl_byte_valid),
    .dl_byte(dl_byte), .dl_ready(dl_ready), .dl_done(dl_done),
    .dl_words(dl_words), .dl_overflow(dl_overflow)
  );

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  function automatic void fail(string name);
    checks++;
    $display("FAIL %s: got event expected none/bounded wait", name);
  endfunction

  always @(posedge clock) fv <= fetch_en;

  always @(negedge clock) begin
    if (mon_on) begin
      if (cpu_hold) check("hold_nop", Jpadr, 0);
      if (fv) begin
        if (fetch_q.size() == 0) fail("fetch_unexpected");
        else begin
          check("fetch", Jpadr, fetch_q.pop_front());
          check("fetch_no_hold", cpu_hold, 0);
        end
      end
      if (dl_done) begin
        if (words_q.size() == 0) fail("done_unexpected");
        else begin
          check("dl_words", dl_words, words_q.pop_front());
          check("dl_overflow", dl_overflow, ovf_q.pop_front());
        end
      end
    end
  end

  task automatic fetch(input int a);
    @(negedge clock);
    rom_adr_i = AW'(a);
    fetch_en = 1;
    fetch_q.push_back(model[a]);
  endtask

  task automatic fetch_end();
    @(negedge clock);
    fetch_en = 0;
  endtask

  task automatic verify_mem();
    for (int a = 0; a < DEPTH; a++) if (known[a]) fetch(a);
    fetch_end();
  endtask

  task automatic run_session();
    int n, attempted, written, to;
    logic [31:0] w;
    n = sess.size();
    attempted = (n + 3) / 4;
    written = attempted < DEPTH ? attempted : DEPTH;
    words_q.push_back((AW+1)'(written));
    ovf_q.push_back(attempted >= DEPTH);
    for (int i = 0; i < written; i++) begin
      w = '0;
      for (int k = 0; k < 4; k++)
        if (4*i + k < n) w = w | (32'(sess[4*i + k]) << (24 - 8*k));
      model[i] = w;
      known[i] = 1;
    end
    @(negedge clock);
    dl_mode = 1;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3) == 0 ? $urandom_range(1, 2) : 0) begin
        @(negedge clock);
        dl_byte_valid = 0;
        dl_byte = 8'($urandom);
      end
      @(negedge clock);
      dl_byte_valid = 1;
      dl_byte = sess[i];
      if (i == n - 1 && dl_ready && $urandom_range(0, 1) == 1) dl_mode = 0;
      to = 0;
      while (!dl_ready && to < 20) begin
        @(negedge clock);
        to++;
      end
      if (!dl_ready) fail("accept_timeout");
      @(posedge clock);
    end
    @(negedge clock);
    dl_byte_valid = 0;
    dl_mode = 0;
    to = 0;
    while (cpu_hold && to < 50) begin
      @(negedge clock);
      to++;
    end
    if (cpu_hold) fail("session_end_timeout");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clock);
    reset = 0;
    mon_on = 1;
    check("rst_Jpadr", Jpadr, 0);
    check("rst_cpu_hold", cpu_hold, 0);
    check("rst_dl_ready", dl_ready, 0);
    check("rst_dl_done", dl_done, 0);
    check("rst_dl_words", dl_words, 0);
    check("rst_dl_overflow", dl_overflow, 0);
    sess = '{8'h00, 8'h43, 8'h08, 8'h20, 8'h11, 8'h81, 8'hFF, 8'hFF};
    run_session();
    check("t1_model0", model[0], 32'h00430820);
    fetch(1);
    fetch_end();
    fetch(0); fetch(1); fetch(0);
    fetch_end();
    sess = '{8'h01, 8'h04, 8'h40, 8'h22, 8'h15, 8'h00};
    run_session();
    verify_mem();
    sess = {};
    run_session();
    sess = {};
    for (int i = 0; i < 4*DEPTH + 4; i++) sess.push_back(8'($urandom));
    run_session();
    verify_mem();
    @(negedge clock);
    dl_mode = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      dl_byte_valid = 1;
      dl_byte = 8'($urandom);
      for (int t = 0; t < 5 && !dl_ready; t++) @(negedge clock);
      @(posedge clock);
    end
    @(negedge clock);
    reset = 1;
    dl_mode = 0;
    dl_byte_valid = 0;
    @(negedge clock);
    reset = 0;
    check("mid_rst_cpu_hold", cpu_hold, 0);
    check("mid_rst_Jpadr", Jpadr, 0);
    check("mid_rst_dl_words", dl_words, 0);
    check("mid_rst_dl_overflow", dl_overflow, 0);
    check("mid_rst_dl_ready", dl_ready, 0);
    verify_mem();
    repeat (10) begin
      sess = {};
      repeat ($urandom_range(0, 4*DEPTH + 6)) sess.push_back(8'($urandom));
      run_session();
      verify_mem();
      for (int k = 0; k < 3; k++) fetch($urandom_range(0, 1));
      fetch_end();
    end
    repeat (3) @(negedge clock);
    check("fetch_q_drained", fetch_q.size(), 0);
    check("done_q_drained", words_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
